imem_loader: RTL

//  Boot-time program loader: the write side of the 16-bit core's instruction memory.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port of the boot loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [15:0] imem_wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a framed byte stream (count, hi/lo words,
// XOR checksum), writes each word to inst_mem, and releases the CPU only after a good load.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [8:0]        words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_CNT, S_GET_HI, S_GET_LO, S_WRITE, S_GET_SUM, S_DONE, S_ERROR
  } state_e;

  function automatic logic [7:0] cks_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    cks_q, cks_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [8:0]    words_q, words_d;
  logic          rx_ready_s;
  logic          hs_s;

  assign rx_ready_s = (state_q == S_GET_CNT) || (state_q == S_GET_HI) ||
                      (state_q == S_GET_LO)  || (state_q == S_GET_SUM);
  assign hs_s       = bus.rx_valid && rx_ready_s;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    cks_d       = cks_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    words_d     = words_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_GET_CNT;
          cks_d       = 8'h00;
          addr_d      = BASE_ADDR;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          words_d     = 9'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_GET_CNT: begin
        if (hs_s) begin
          cnt_d   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          state_d = S_GET_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_GET_HI: begin
        if (hs_s) begin
          hi_d    = bus.rx_data;
          cks_d   = cks_next(cks_q, bus.rx_data);
          state_d = S_GET_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_GET_LO: begin
        if (hs_s) begin
          cks_d   = cks_next(cks_q, bus.rx_data);
          data_d  = {hi_q, bus.rx_data};
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        words_d = words_q + 9'd1;
        addr_d  = addr_q + 8'd1;
        state_d = ((words_q + 9'd1) == cnt_q) ? S_GET_SUM : S_GET_HI;
      end
      S_GET_SUM: begin
        if (hs_s && (bus.rx_data == cks_q)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
        end else if (hs_s) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stall watchdog: only idle receive cycles count; a handshake in the final cycle wins.
    if (!rx_ready_s || hs_s) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d       = '0;
      state_d     = S_ERROR;
      error_d     = 1'b1;
      busy_d      = 1'b0;
      cpu_reset_d = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      hi_q        <= 8'h00;
      cks_q       <= 8'h00;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= BASE_ADDR;
      data_q      <= 16'h0000;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= 9'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      cks_q       <= cks_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      words_q     <= words_d;
    end
  end

  assign bus.rx_ready     = rx_ready_s;
  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = addr_q;
  assign bus.imem_wr_data = data_q;
  assign cpu_reset        = cpu_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_loaded     = words_q;

endmodule
